// File: rtl/dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm_access_ctrl
// Purpose  : Sequencer/arbiter in front of the word-only data memory. Shares
//            DM between the M-stage CPU port and a debug/loader port with
//            round-robin arbitration, and turns byte/halfword stores into a
//            read-modify-write pair because DM only writes whole words.
// Ports    : clk, reset (async, active-high)
//            cpu_* : CPU request port   (req/we/be/addr/wdata/pc -> ready/rdata)
//            dbg_* : debug request port (req/we/be/addr/wdata    -> ready/rdata)
//            dm_*  : straight connection to DM (pc/write/addr_byte/wdata/rdata)
// Options  : `define DM_CTRL_TRACE_EN prints every DM write cycle.
// Revision : 1.0 - initial release
// ============================================================================
module dm_access_ctrl #(
    parameter int          ADDR_W = 14,
    parameter logic [31:0] DBG_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    // CPU port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [31:0]       cpu_pc,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    // Debug port
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [3:0]        dbg_be,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_ready,
    output logic [31:0]       dbg_rdata,
    // Data memory side
    output logic [31:0]       dm_pc,
    output logic              dm_write,
    output logic [ADDR_W-1:0] dm_addr_byte,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACCESS   = 2'd1;
    localparam logic [1:0] ST_MERGE_WR = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DBG = 1'b1;

    logic [1:0]        state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q,      grant_d;
    logic              we_q,         we_d;
    logic [3:0]        be_q,         be_d;
    logic [ADDR_W-3:0] addr_q,       addr_d;   // word index only
    logic [31:0]       wdata_q,      wdata_d;
    logic [31:0]       pc_q,         pc_d;
    logic [31:0]       merged_q,     merged_d;
    logic [31:0]       cpu_rdata_q,  cpu_rdata_d;
    logic [31:0]       dbg_rdata_q,  dbg_rdata_d;

    logic              w_pick_dbg;
    logic              w_full;
    logic              w_partial;
    logic [31:0]       w_merged;
    logic              w_unused_addr_lsbs;

    // Byte offsets are irrelevant to a word-only memory.
    assign w_unused_addr_lsbs = ^{cpu_addr[1:0], dbg_addr[1:0]};

    // Debug wins when it is the only requester, or on a tie when the CPU
    // had the previous grant.
    assign w_pick_dbg = dbg_req && (!cpu_req || (last_grant_q == GNT_CPU));

    assign w_full    = we_q && (be_q == 4'hF);
    assign w_partial = we_q && (be_q != 4'h0) && (be_q != 4'hF);

    always_comb begin
        w_merged = '0;
        for (int i = 0; i < 4; i++) begin
            w_merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : dm_rdata[8*i +: 8];
        end
    end

    // Next-state / register update logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        pc_d         = pc_q;
        merged_d     = merged_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req || dbg_req) begin
                    if (w_pick_dbg) begin
                        grant_d = GNT_DBG;
                        we_d    = dbg_we;
                        be_d    = dbg_be;
                        addr_d  = dbg_addr[ADDR_W-1:2];
                        wdata_d = dbg_wdata;
                        pc_d    = DBG_PC;
                    end else begin
                        grant_d = GNT_CPU;
                        we_d    = cpu_we;
                        be_d    = cpu_be;
                        addr_d  = cpu_addr[ADDR_W-1:2];
                        wdata_d = cpu_wdata;
                        pc_d    = cpu_pc;
                    end
                    last_grant_d = w_pick_dbg ? GNT_DBG : GNT_CPU;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_partial) begin
                    merged_d = w_merged;
                    state_d  = ST_MERGE_WR;
                end else begin
                    // Loads, empty stores and full stores all return the
                    // word present before any write this cycle.
                    if (grant_q == GNT_DBG) begin
                        dbg_rdata_d = dm_rdata;
                    end else begin
                        cpu_rdata_d = dm_rdata;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_MERGE_WR: state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_DBG;
            grant_q      <= GNT_CPU;
            we_q         <= 1'b0;
            be_q         <= 4'h0;
            addr_q       <= '0;
            wdata_q      <= '0;
            pc_q         <= '0;
            merged_q     <= '0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            pc_q         <= pc_d;
            merged_q     <= merged_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    // Memory-side drive: decoded from state so an asynchronous reset kills
    // any write in flight at once.
    always_comb begin
        dm_write     = 1'b0;
        dm_wdata     = '0;
        dm_pc        = '0;
        dm_addr_byte = '0;
        case (state_q)
            ST_ACCESS: begin
                dm_pc        = pc_q;
                dm_addr_byte = {addr_q, 2'b00};
                if (w_full) begin
                    dm_write = 1'b1;
                    dm_wdata = wdata_q;
                end
            end
            ST_MERGE_WR: begin
                dm_pc        = pc_q;
                dm_addr_byte = {addr_q, 2'b00};
                dm_write     = 1'b1;
                dm_wdata     = merged_q;
            end
            default: ;
        endcase
    end

    assign cpu_ready = (state_q == ST_DONE) && (grant_q == GNT_CPU);
    assign dbg_ready = (state_q == ST_DONE) && (grant_q == GNT_DBG);
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

`ifdef DM_CTRL_TRACE_EN
    always @(posedge clk) begin
        if (dm_write) begin
            $display("%d@%h: *%h <= %h", $time, dm_pc,
                     {{(32-ADDR_W){1'b0}}, dm_addr_byte}, dm_wdata);
        end
    end
`else
`endif

endmodule
`default_nettype wire

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Sequencer and arbiter in front of the word-only data memory (DM).
- Shares DM between two requesters: the M-stage CPU port and a debug/loader port.
- Converts byte/halfword stores (byte enables) into a read-modify-write pair, because DM writes only whole words.
- Sits between stage_M and the DM instance. Its memory-side ports connect straight to DM's pc/mem_write/mem_addr_byte/mem_data/dm_out.

Parameters:
- ADDR_W, 14, byte-address width of DM.
- DBG_PC, 32'h0000_0000, PC value reported to DM for debug-port writes.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU request. Held high until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_be  in  4  byte enables; bit i selects byte lane i.
- cpu_addr  in  ADDR_W  byte address; low 2 bits ignored.
- cpu_wdata  in  32  store data, already lane-aligned.
- cpu_pc  in  32  PC of the issuing instruction.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  load word; valid while cpu_ready=1.
- dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata  in  1/1/4/ADDR_W/32  debug port; same meaning as the CPU port.
- dbg_ready  out  1  debug completion pulse.
- dbg_rdata  out  32  debug load word; valid while dbg_ready=1.
- dm_pc  out  32  PC forwarded to DM.
- dm_write  out  1  DM write enable.
- dm_addr_byte  out  ADDR_W  DM byte address, always word-aligned.
- dm_wdata  out  32  DM write data.
- dm_rdata  in  32  DM combinational read data.

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous, active-high.
- Reset state: FSM in IDLE; last_grant = DBG.
- Reset output values: cpu_ready, dbg_ready, dm_write = 0; cpu_rdata, dbg_rdata, dm_pc, dm_addr_byte, dm_wdata = 0.
- FSM states: IDLE, ACCESS, MERGE_WR, DONE.
- IDLE:
  - If any req is high, arbitrate and latch we/be/addr/wdata/pc of the winner into registers, plus grant id. Next state ACCESS.
  - Debug-port latched pc = DBG_PC.
  - No req: stay in IDLE.
- Arbitration:
  - Round-robin on simultaneous requests; the requester not equal to last_grant wins.
  - last_grant updates on every grant.
  - After reset, CPU wins the first tie.
- ACCESS:
  - dm_addr_byte = {addr[ADDR_W-1:2],2'b00}; dm_pc = latched pc.
  - Load, or store with be=4'b0000: rdata_reg <= dm_rdata, dm_write=0. Next DONE.
  - Store with be=4'b1111: dm_write=1, dm_wdata=wdata, rdata_reg <= dm_rdata (old value). Next DONE.
  - Partial store (any other be): merged <= byte i from wdata if be[i], else from dm_rdata; dm_write=0. Next MERGE_WR.
- MERGE_WR: same address; dm_write=1, dm_wdata=merged. Next DONE.
- DONE:
  - Granted requester's ready=1 for exactly one cycle.
  - Its rdata output = rdata_reg; the other requester's ready stays 0.
  - Next IDLE.
- dm_write is 0 in every state and case except those listed above.
- Latency, with req sampled in IDLE at cycle T:
  - Load or full store: ready at T+2.
  - Partial store: ready at T+3.
  - Back-to-back: a held req is re-sampled in IDLE at T+3 (or T+4 for a partial store).
- Requests are latched at grant. A req that drops or changes mid-transaction does not abort it; ready still pulses.
- Ungranted requester: its inputs are ignored; its req stays pending until it wins IDLE.
- Reset mid-transaction: abort immediately; no DM write, no ready pulse; return to IDLE.
- rdata outputs hold their value between completions.

Optional Feature:
- Macro: DM_CTRL_TRACE_EN.
- Defined: on every cycle with dm_write=1, $display "%d@%h: *%h <= %h" with $time, dm_pc, zero-extended dm_addr_byte, dm_wdata. Partial stores print the merged word only.
- Undefined: no display statements; RTL is otherwise identical.

Test Plan:
- CPU load only: preload DM[0x10]=32'hDEADBEEF; cpu_req, we=0, addr=14'h0010 -> cpu_ready at T+2, cpu_rdata=32'hDEADBEEF, dm_write never 1.
- CPU full store: we=1, be=4'hF, addr=14'h0013, wdata=32'h12345678 -> one dm_write cycle at ACCESS with dm_addr_byte=14'h0010, then cpu_ready at T+2.
- Partial store RMW: DM[0x20]=32'hAABBCCDD; be=4'b0100, wdata=32'h00EE0000 -> ACCESS has dm_write=0; MERGE_WR writes 32'hAAEECCDD; ready at T+3.
- Tie arbitration: cpu_req and dbg_req held together from reset -> grants in order CPU, DBG, CPU, DBG; each ready pulse goes only to the granted port.
- Reset mid-op: assert reset during MERGE_WR of a partial store -> no dm_write, no ready pulse; after release FSM is in IDLE and all outputs are 0.
- be=0 store: we=1, be=4'b0000 -> dm_write stays 0; ready at T+2.
